// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of the 5-stage RISC-V pipeline. Issues
//            loads/stores on a req/ack data-memory bus with byte-lane
//            alignment, sign/zero-extends load data, stalls the upstream
//            pipeline while an access is outstanding and registers the
//            write-back value into the MEM/WB boundary.
// Ports    : clk, rst_n (sync, active-low)
//            mem_*      : registered EX/MEM control and data (inputs)
//            dmem_*     : data-memory request/acknowledge bus
//            mem_stall  : combinational freeze of IF..EX/MEM
//            mem_misalign : one-cycle misaligned-access pulse
//            wb_*       : MEM/WB register outputs
// Options  : MEM_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//            accesses are trapped instead of issued on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_MemRW,
   input  logic        mem_MemRead,
   input  logic        mem_RegWEn,
   input  logic [2:0]  mem_funct3,
   input  logic [1:0]  mem_WBSel,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_ALU_out,
   input  logic [31:0] mem_DataB,
   input  logic [31:0] mem_pc,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        mem_misalign,
   output logic        wb_RegWEn,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        w_access;
   logic        w_misaligned;
   logic        w_trap;
   logic        w_start;
   logic        w_done;

   logic [3:0]  w_be;
   logic [31:0] w_wdata;

   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic [4:0]  r_rd;
   logic        r_regwen;
   logic        r_is_load;

   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [31:0] w_ld_data;
   logic [31:0] w_wb_sel;

   assign w_access = mem_MemRW | mem_MemRead;

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_misaligned = ((mem_funct3[1:0] == 2'b01) &&  mem_ALU_out[0]) ||
                         ((mem_funct3[1:0] == 2'b10) && (mem_ALU_out[1:0] != 2'b00));
`else
   assign w_misaligned = 1'b0;
`endif

   // Trap is only evaluated while idle; in BUSY the inputs are frozen anyway.
   assign w_trap = (r_state == S_IDLE) && w_access && w_misaligned;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done      = 1'b0;
      mem_stall   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access && !w_misaligned) begin
               w_start     = 1'b1;
               mem_stall   = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (dmem_ack) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               mem_stall   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------- store lane steering
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = mem_DataB;
      case (mem_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << mem_ALU_out[1:0];
            w_wdata = {4{mem_DataB[7:0]}};
         end
         2'b01: begin
            w_be    = mem_ALU_out[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem_DataB[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = mem_DataB;
         end
      endcase
   end

   // ---------------------------------------------------- load extraction
   always_comb begin
      w_ld_byte = dmem_rdata[7:0];
      case (r_off)
         2'd0:    w_ld_byte = dmem_rdata[7:0];
         2'd1:    w_ld_byte = dmem_rdata[15:8];
         2'd2:    w_ld_byte = dmem_rdata[23:16];
         default: w_ld_byte = dmem_rdata[31:24];
      endcase
      w_ld_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b100:  w_ld_data = {24'd0, w_ld_byte};
         3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'b101:  w_ld_data = {16'd0, w_ld_half};
         default: w_ld_data = dmem_rdata;
      endcase
   end

   // Non-memory write-back select; 2'b00 without a load has no data source.
   always_comb begin
      case (mem_WBSel)
         2'b00:   w_wb_sel = 32'd0;
         2'b10:   w_wb_sel = mem_pc + 32'd4;
         default: w_wb_sel = mem_ALU_out;
      endcase
   end

   // ---------------------------------------------- bus and MEM/WB registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'd0;
         dmem_wdata <= 32'd0;
         dmem_be    <= 4'd0;
         r_funct3   <= 3'd0;
         r_off      <= 2'd0;
         r_rd       <= 5'd0;
         r_regwen   <= 1'b0;
         r_is_load  <= 1'b0;
         wb_RegWEn  <= 1'b0;
         wb_rd      <= 5'd0;
         wb_data    <= 32'd0;
      end else begin
         if (w_start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_MemRW;
            dmem_addr  <= {mem_ALU_out[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
            r_funct3   <= mem_funct3;
            r_off      <= mem_ALU_out[1:0];
            r_rd       <= mem_rd;
            r_regwen   <= mem_RegWEn;
            r_is_load  <= mem_MemRead;
         end else if (w_done) begin
            dmem_req   <= 1'b0;
         end

         if (w_done) begin
            wb_RegWEn <= r_regwen & r_is_load;
            wb_rd     <= r_rd;
            wb_data   <= r_is_load ? w_ld_data : 32'd0;
         end else if (mem_stall || w_trap) begin
            // bubble: data holds so the visible value only changes on results
            wb_RegWEn <= 1'b0;
            wb_rd     <= 5'd0;
         end else begin
            wb_RegWEn <= mem_RegWEn;
            wb_rd     <= mem_rd;
            wb_data   <= w_wb_sel;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst_n) mem_misalign <= 1'b0;
      else        mem_misalign <= w_trap;
   end
`else
   assign mem_misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: directed vector table,
//            randomized operations checked against an arithmetic model, and
//            hand-written reset-mid-access / idle-ack / misalign sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_MemRW, mem_MemRead, mem_RegWEn;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_WBSel;
   logic [4:0]  mem_rd;
   logic [31:0] mem_ALU_out, mem_DataB, mem_pc;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        mem_stall, mem_misalign, wb_RegWEn;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .mem_MemRW(mem_MemRW), .mem_MemRead(mem_MemRead), .mem_RegWEn(mem_RegWEn),
      .mem_funct3(mem_funct3), .mem_WBSel(mem_WBSel), .mem_rd(mem_rd),
      .mem_ALU_out(mem_ALU_out), .mem_DataB(mem_DataB), .mem_pc(mem_pc),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_misalign(mem_misalign),
      .wb_RegWEn(wb_RegWEn), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   typedef struct {
      logic        st;
      logic        ld;
      logic        regwen;
      logic [2:0]  f3;
      logic [1:0]  wbsel;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] datab;
      logic [31:0] pc;
      int          delay;
      logic [31:0] rdata;
      logic [31:0] exp_data;
      logic        exp_regwen;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: derives expectations from access size, lane and sign.
   function automatic vec_t model(input vec_t v);
      vec_t   r = v;
      int     nbytes, lane;
      longint raw;
      nbytes = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
      lane   = (nbytes == 1) ? int'(v.alu % 4) : (nbytes == 2) ? int'(v.alu % 4) / 2 * 2 : 0;
      r.exp_be    = 4'(((1 << nbytes) - 1) << lane);
      r.exp_wdata = (nbytes == 1) ? (v.datab % 256) * 32'h0101_0101 :
                    (nbytes == 2) ? (v.datab % 65536) * 32'h0001_0001 : v.datab;
      if (v.st) begin
         r.exp_data   = 32'd0;
         r.exp_regwen = 1'b0;
      end else if (v.ld) begin
         raw = (longint'(v.rdata) >> (8 * lane)) % (longint'(1) << (8 * nbytes));
         if (!v.f3[2] && nbytes < 4 && raw >= (longint'(1) << (8 * nbytes - 1)))
            raw = raw - (longint'(1) << (8 * nbytes));
         r.exp_data   = 32'(raw);
         r.exp_regwen = v.regwen;
      end else begin
         r.exp_data   = (v.wbsel == 2'b10) ? v.pc + 32'd4 : v.alu;
         r.exp_regwen = v.regwen;
      end
      return r;
   endfunction

   task automatic drive(input vec_t v);
      mem_MemRW   = v.st;
      mem_MemRead = v.ld;
      mem_RegWEn  = v.regwen;
      mem_funct3  = v.f3;
      mem_WBSel   = v.wbsel;
      mem_rd      = v.rd;
      mem_ALU_out = v.alu;
      mem_DataB   = v.datab;
      mem_pc      = v.pc;
   endtask

   task automatic drive_nop();
      vec_t n = '{default: '0};
      drive(n);
   endtask

   // Called at posedge+1; returns at posedge+1 after the result edge.
   task automatic run_vec(input vec_t v, input string tag);
      int cnt = 0;
      drive(v);
      #1;
      if (!(v.st || v.ld)) begin
         chk({tag, " alu_stall"}, 32'(mem_stall), 32'd0);
         @(posedge clk); #1;
      end else begin
         if (mem_stall) cnt++;
         @(posedge clk); #1;
         chk({tag, " req"}, 32'(dmem_req), 32'd1);
         chk({tag, " we"}, 32'(dmem_we), 32'(v.st));
         chk({tag, " addr"}, dmem_addr, v.alu & 32'hFFFF_FFFC);
         chk({tag, " wb_bubble"}, 32'(wb_RegWEn), 32'd0);
         if (v.st) begin
            chk({tag, " be"}, 32'(dmem_be), 32'(v.exp_be));
            chk({tag, " wdata"}, dmem_wdata, v.exp_wdata);
         end
         for (int k = 0; k < v.delay; k++) begin
            if (mem_stall) cnt++;
            @(posedge clk); #1;
            chk({tag, " req_hold"}, 32'(dmem_req), 32'd1);
            chk({tag, " addr_hold"}, dmem_addr, v.alu & 32'hFFFF_FFFC);
            chk({tag, " wait_bubble"}, 32'(wb_RegWEn), 32'd0);
         end
         if (mem_stall) cnt++;
         @(negedge clk);
         dmem_ack   = 1'b1;
         dmem_rdata = v.rdata;
         #1;
         chk({tag, " stall_ack"}, 32'(mem_stall), 32'd0);
         @(posedge clk); #1;
         dmem_ack   = 1'b0;
         dmem_rdata = $urandom;
         chk({tag, " req_drop"}, 32'(dmem_req), 32'd0);
         chk({tag, " stall_cycles"}, 32'(cnt), 32'(v.delay + 2));
      end
      chk({tag, " wb_RegWEn"}, 32'(wb_RegWEn), 32'(v.exp_regwen));
      chk({tag, " wb_data"}, wb_data, v.exp_data);
      if (!v.st) chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
   endtask

   vec_t tbl[12];
   vec_t rv;

   initial begin
      //            st ld we f3      wb     rd   alu           datab          pc            dly rdata          exp_data       exp_we be       exp_wdata
      tbl[0]  = '{0, 0, 1, 3'b000, 2'b01, 5,  32'h1234,     32'h0,         32'h0,        0, 32'h0,         32'h1234,      1, 4'b0000, 32'h0};
      tbl[1]  = '{1, 0, 0, 3'b000, 2'b00, 0,  32'h103,      32'hAB,        32'h0,        0, 32'h0,         32'h0,         0, 4'b1000, 32'hABABABAB};
      tbl[2]  = '{0, 1, 1, 3'b000, 2'b00, 7,  32'h102,      32'h0,         32'h0,        0, 32'h00800000,  32'hFFFFFF80,  1, 4'b0000, 32'h0};
      tbl[3]  = '{0, 1, 1, 3'b101, 2'b00, 8,  32'h102,      32'h0,         32'h0,        0, 32'h80010000,  32'h00008001,  1, 4'b0000, 32'h0};
      tbl[4]  = '{0, 1, 1, 3'b010, 2'b00, 9,  32'h200,      32'h0,         32'h0,        3, 32'hDEADBEEF,  32'hDEADBEEF,  1, 4'b0000, 32'h0};
      tbl[5]  = '{0, 0, 1, 3'b000, 2'b10, 10, 32'h77,       32'h0,         32'hFFFFFFFC, 0, 32'h0,         32'h0,         1, 4'b0000, 32'h0};
      tbl[6]  = '{0, 0, 1, 3'b000, 2'b11, 11, 32'h55,       32'h0,         32'h400,      0, 32'h0,         32'h55,        1, 4'b0000, 32'h0};
      tbl[7]  = '{1, 0, 1, 3'b001, 2'b00, 3,  32'h102,      32'h1234ABCD,  32'h0,        0, 32'h0,         32'h0,         0, 4'b1100, 32'hABCDABCD};
      tbl[8]  = '{1, 0, 0, 3'b010, 2'b00, 0,  32'h40,       32'h01020304,  32'h0,        1, 32'h0,         32'h0,         0, 4'b1111, 32'h01020304};
      tbl[9]  = '{0, 1, 1, 3'b001, 2'b00, 12, 32'h100,      32'h0,         32'h0,        0, 32'h00008001,  32'hFFFF8001,  1, 4'b0000, 32'h0};
      tbl[10] = '{0, 1, 1, 3'b100, 2'b00, 13, 32'h101,      32'h0,         32'h0,        2, 32'h0000F100,  32'h000000F1,  1, 4'b0000, 32'h0};
      tbl[11] = '{0, 0, 0, 3'b000, 2'b01, 14, 32'hCAFE,     32'h0,         32'h0,        0, 32'h0,         32'hCAFE,      0, 4'b0000, 32'h0};

      // ---------------------------------------------------------- reset
      rst_n      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      drive_nop();
      repeat (3) @(posedge clk);
      #1;
      chk("rst req", 32'(dmem_req), 32'd0);
      chk("rst we", 32'(dmem_we), 32'd0);
      chk("rst be", 32'(dmem_be), 32'd0);
      chk("rst addr", dmem_addr, 32'd0);
      chk("rst wdata", dmem_wdata, 32'd0);
      chk("rst wb_RegWEn", 32'(wb_RegWEn), 32'd0);
      chk("rst wb_rd", 32'(wb_rd), 32'd0);
      chk("rst wb_data", wb_data, 32'd0);
      chk("rst misalign", 32'(mem_misalign), 32'd0);
      rst_n = 1'b1;

      // ---------------------------------------------------- directed table
      for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // ------------------------------------------------ randomized vs model
      for (int i = 0; i < 60; i++) begin
         int kind;
         rv = '{default: '0};
         kind     = $urandom_range(0, 2);
         rv.rd    = 5'($urandom);
         rv.alu   = $urandom;
         rv.datab = $urandom;
         rv.pc    = $urandom;
         rv.rdata = $urandom;
         rv.regwen = 1'($urandom);
         rv.delay = $urandom_range(0, 3);
         if (kind == 0) begin
            rv.wbsel = 2'($urandom_range(1, 3));
         end else if (kind == 1) begin
            int f3s[5] = '{0, 1, 2, 4, 5};
            rv.ld = 1'b1;
            rv.f3 = 3'(f3s[$urandom_range(0, 4)]);
         end else begin
            rv.st = 1'b1;
            rv.f3 = 3'($urandom_range(0, 2));
         end
`ifdef MEM_MISALIGN_TRAP_EN
         if (rv.f3[1:0] == 2'b01) rv.alu[0]   = 1'b0;
         if (rv.f3[1:0] == 2'b10) rv.alu[1:0] = 2'b00;
`endif
         rv = model(rv);
         run_vec(rv, $sformatf("rnd%0d", i));
      end
      chk("misalign idle", 32'(mem_misalign), 32'd0);

      // ----------------------------------------------- reset while BUSY
      rv = '{default: '0};
      rv.ld = 1'b1; rv.regwen = 1'b1; rv.f3 = 3'b010; rv.rd = 5'd20; rv.alu = 32'h300;
      drive(rv);
      @(posedge clk); #1;
      chk("mid req", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive_nop();
      @(posedge clk); #1;
      chk("mid rst req", 32'(dmem_req), 32'd0);
      chk("mid rst addr", dmem_addr, 32'd0);
      chk("mid rst wb_data", wb_data, 32'd0);
      chk("mid rst wb_RegWEn", 32'(wb_RegWEn), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1111_2222;
      #1;
      chk("idle ack stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("idle ack req", 32'(dmem_req), 32'd0);
      chk("idle ack wb_RegWEn", 32'(wb_RegWEn), 32'd0);
      chk("idle ack wb_data", wb_data, 32'd0);

      // ------------------------------------------- misaligned word store
      rv = '{default: '0};
      rv.st = 1'b1; rv.f3 = 3'b010; rv.alu = 32'h102; rv.datab = 32'h89ABCDEF;
`ifdef MEM_MISALIGN_TRAP_EN
      drive(rv);
      #1;
      chk("mis stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      drive_nop();
      chk("mis pulse", 32'(mem_misalign), 32'd1);
      chk("mis req", 32'(dmem_req), 32'd0);
      chk("mis wb_RegWEn", 32'(wb_RegWEn), 32'd0);
      @(posedge clk); #1;
      chk("mis pulse end", 32'(mem_misalign), 32'd0);
`else
      rv = model(rv);
      run_vec(rv, "sw_unaligned");
      chk("no misalign", 32'(mem_misalign), 32'd0);
`endif

      rv = '{default: '0};
      rv.regwen = 1'b1; rv.wbsel = 2'b01; rv.rd = 5'd31; rv.alu = 32'hFEED;
      rv = model(rv);
      run_vec(rv, "post");
      drive_nop();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
